// File: rtl/alu_sequencer_if.sv
// Command and result handshake bundle between a command source and alu_sequencer.
interface alu_sequencer_if #(
   parameter int BITW = 8
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [1:0]      cmd_op;
   logic [BITW-1:0] cmd_a;
   logic [BITW-1:0] cmd_b;
   logic            res_valid;
   logic            res_ready;
   logic [BITW-1:0] res_data;
   logic            res_zero;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
      input  cmd_ready, res_valid, res_data, res_zero
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
      output cmd_ready, res_valid, res_data, res_zero
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: command front-end for the two-register alu. Loads operands
// over the shared bus, issues the compute opcode, captures the result on the
// falling edge and offers it on a valid/ready port.
// Optional feature macro: ALU_SEQ_SKIP_EN (shadow copies of the ALU registers
// let a command skip operand writes the ALU already holds).
//
// state | meaning
// IDLE  | ready for a command, bus released
// W0    | drive operand a, ALU writes register 0
// W1    | drive operand b, ALU writes register 1
// EX    | bus released, compute opcode issued
// CAP   | ALU drives result, captured on falling edge
// DONE  | result offered until res_ready
module alu_sequencer #(
   parameter int BITW = 8
) (
   input  logic           clock,
   input  logic           n_reset,
   alu_sequencer_if.slave sif,
   output logic [2:0]     alu_op,
   inout  wire [BITW-1:0] bus
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_W0   = 3'd1,
      S_W1   = 3'd2,
      S_EX   = 3'd3,
      S_CAP  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [2:0] ALU_NOP = 3'd0;
   localparam logic [2:0] ALU_ADD = 3'd1;
   localparam logic [2:0] ALU_INC = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_WR0 = 3'd6;
   localparam logic [2:0] ALU_WR1 = 3'd7;

   localparam logic [1:0] CMD_ADD = 2'd0;
   localparam logic [1:0] CMD_SUB = 2'd1;
   localparam logic [1:0] CMD_INC = 2'd2;

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [BITW-1:0] a_q, a_d;
   logic [BITW-1:0] b_q, b_d;
   logic [BITW-1:0] res_q, res_d;
   logic            bus_en_q, bus_en_d;
   logic            skip1_q, skip1_d;
   logic            skip0;
   logic            skip1;

`ifdef ALU_SEQ_SKIP_EN
   logic [BITW-1:0] sh0_q, sh0_d;
   logic [BITW-1:0] sh1_q, sh1_d;
   logic            sh0_v_q, sh0_v_d;
   logic            sh1_v_q, sh1_v_d;

   // Shadows follow whatever value each write state hands to the ALU.
   always_comb begin
      sh0_d   = sh0_q;
      sh1_d   = sh1_q;
      sh0_v_d = sh0_v_q;
      sh1_v_d = sh1_v_q;
      if (state_q == S_W0) begin
         sh0_d   = a_q;
         sh0_v_d = 1'b1;
      end
      if (state_q == S_W1) begin
         sh1_d   = b_q;
         sh1_v_d = 1'b1;
      end
   end

   // Shadow registers; reset invalidates both since the ALU contents are unknown.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         sh0_q   <= '0;
         sh1_q   <= '0;
         sh0_v_q <= 1'b0;
         sh1_v_q <= 1'b0;
      end else begin
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         sh0_v_q <= sh0_v_d;
         sh1_v_q <= sh1_v_d;
      end
   end

   assign skip0 = sh0_v_q && (sh0_q == sif.cmd_a);
   assign skip1 = sh1_v_q && (sh1_q == sif.cmd_b);
`else
   assign skip0 = 1'b0;
   assign skip1 = 1'b0;
`endif

   // Next-state, command latch and ALU opcode decode.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      skip1_d = skip1_q;
      alu_op  = ALU_NOP;
      case (state_q)
         S_IDLE: begin
            if (sif.cmd_valid) begin
               op_d    = sif.cmd_op;
               a_d     = sif.cmd_a;
               b_d     = sif.cmd_b;
               skip1_d = skip1;
               case (sif.cmd_op)
                  CMD_ADD, CMD_SUB: state_d = skip0 ? (skip1 ? S_EX : S_W1) : S_W0;
                  CMD_INC:          state_d = skip1 ? S_EX : S_W1;
                  default:          state_d = S_IDLE;
               endcase
            end
         end
         S_W0: begin
            alu_op  = ALU_WR0;
            state_d = skip1_q ? S_EX : S_W1;
         end
         S_W1: begin
            alu_op  = ALU_WR1;
            state_d = S_EX;
         end
         S_EX: begin
            case (op_q)
               CMD_ADD: alu_op = ALU_ADD;
               CMD_SUB: alu_op = ALU_SUB;
               default: alu_op = ALU_INC;
            endcase
            state_d = S_CAP;
         end
         S_CAP:  state_d = S_DONE;
         S_DONE: if (sif.res_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      bus_en_d = (state_d == S_W0) || (state_d == S_W1);
   end

   // State, command latch and registered bus enable.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         skip1_q  <= 1'b0;
         bus_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         skip1_q  <= skip1_d;
         bus_en_q <= bus_en_d;
      end
   end

   // The ALU drives the bus only while the clock is high in CAP.
   always_comb begin
      res_d = (state_q == S_CAP) ? bus : res_q;
   end

   // Result capture on the falling edge, mid-way through the ALU drive window.
   always_ff @(negedge clock or negedge n_reset) begin
      if (!n_reset) res_q <= '0;
      else          res_q <= res_d;
   end

   assign bus           = bus_en_q ? ((state_q == S_W0) ? a_q : b_q) : 'z;
   assign sif.cmd_ready = n_reset && (state_q == S_IDLE);
   assign sif.res_valid = (state_q == S_DONE);
   assign sif.res_data  = res_q;
   assign sif.res_zero  = (res_q == '0);
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural two-register ALU on the shared bus,
// directed and randomized commands checked against a command-level model.
module tb_alu_sequencer;
   localparam int BITW = 8;

   logic            clock = 1'b0;
   logic            n_reset;
   wire  [2:0]      alu_op;
   wire  [BITW-1:0] bus;

   logic [BITW-1:0] alu_r0 = '0;
   logic [BITW-1:0] alu_r1 = '0;
   logic [BITW-1:0] alu_out = '0;
   logic            alu_oe = 1'b0;
   logic [2:0]      op_s;
   logic [BITW-1:0] bus_s;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int cyc    = 0;

   logic [BITW-1:0] sh [2];
   bit              sh_v [2];

   alu_sequencer_if #(.BITW(BITW)) sif ();

   alu_sequencer #(.BITW(BITW)) dut (
      .clock   (clock),
      .n_reset (n_reset),
      .sif     (sif.slave),
      .alu_op  (alu_op),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   assign bus = alu_oe ? alu_out : 'z;

   // ALU: samples op/bus mid-cycle, acts on the rising edge, drives its
   // result for the following high phase.
   always begin
      @(negedge clock);
      #1;
      alu_oe = 1'b0;
      op_s   = alu_op;
      bus_s  = bus;
      @(posedge clock);
      if (n_reset) begin
         case (op_s)
            3'd6: alu_r0 = bus_s;
            3'd7: alu_r1 = bus_s;
            3'd1: begin alu_out = alu_r0 + alu_r1; alu_oe = 1'b1; end
            3'd3: begin alu_out = alu_r0 - alu_r1; alu_oe = 1'b1; end
            3'd2: begin alu_out = alu_r1 + 8'd1;   alu_oe = 1'b1; end
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sh_v[0] = 1'b0;
      sh_v[1] = 1'b0;
      sh[0]   = '0;
      sh[1]   = '0;
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      model_reset();
      @(negedge clock);
      #1;
      n_reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // One command end to end; expectations come from the command-level model.
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, output int lat, output int acc_cyc);
      logic [7:0] exp_res;
      logic [2:0] exp_ops [$];
      logic [2:0] got_ops [$];
      logic [7:0] got_bus [$];
      logic [7:0] held;
      bit         s0, s1, ok;
      int         n;
      s0 = 1'b0;
      s1 = 1'b0;
`ifdef ALU_SEQ_SKIP_EN
      s0 = sh_v[0] && (sh[0] == a);
      s1 = sh_v[1] && (sh[1] == b);
`endif
      case (op)
         2'd0:    exp_res = a + b;
         2'd1:    exp_res = a - b;
         2'd2:    exp_res = b + 8'd1;
         default: exp_res = 8'd0;
      endcase
      if (op != 2'd2 && !s0) exp_ops.push_back(3'd6);
      if (!s1) exp_ops.push_back(3'd7);
      exp_ops.push_back((op == 2'd0) ? 3'd1 : (op == 2'd1) ? 3'd3 : 3'd2);
      exp_ops.push_back(3'd0);

      n = 0;
      while (!sif.cmd_ready && n < 20) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("cmd_ready_idle", 32'(sif.cmd_ready), 32'd1);

      sif.cmd_op    = op;
      sif.cmd_a     = a;
      sif.cmd_b     = b;
      sif.cmd_valid = 1'b1;
      sif.res_ready = (hold == 0);
      @(posedge clock);
      acc_cyc = cyc;
      #1;
      sif.cmd_valid = 1'b0;
      sif.cmd_a     = 8'($urandom);
      sif.cmd_b     = 8'($urandom);

      if (op == 2'd3) begin
         lat = 0;
         chk("rsvd_ready_next", 32'(sif.cmd_ready), 32'd1);
         ok = 1'b1;
         for (int i = 0; i < 6; i++) begin
            if (sif.res_valid || alu_op != 3'd0) ok = 1'b0;
            @(posedge clock);
            #1;
         end
         chk("rsvd_quiet", 32'(ok), 32'd1);
         sif.res_ready = 1'b0;
         return;
      end

      n = 1;
      while (!sif.res_valid && n < 12) begin
         got_ops.push_back(alu_op);
         got_bus.push_back(bus);
         @(posedge clock);
         #1;
         n++;
      end
      lat = n;
      chk("latency", 32'(n), 32'(exp_ops.size() + 1));
      ok = (got_ops.size() == exp_ops.size());
      if (ok) begin
         for (int i = 0; i < got_ops.size(); i++) begin
            if (got_ops[i] != exp_ops[i]) ok = 1'b0;
            if (got_ops[i] == 3'd6 && got_bus[i] != a) ok = 1'b0;
            if (got_ops[i] == 3'd7 && got_bus[i] != b) ok = 1'b0;
         end
      end
      chk("op_bus_sequence", 32'(ok), 32'd1);
      chk("res_data", 32'(sif.res_data), 32'(exp_res));
      chk("res_zero", 32'(sif.res_zero), 32'(exp_res == 8'd0));
      chk("busy_no_ready", 32'(sif.cmd_ready), 32'd0);

      if (hold > 0) begin
         held = sif.res_data;
         ok   = 1'b1;
         for (int i = 0; i < hold; i++) begin
            if (i == 2) sif.cmd_valid = 1'b1;
            @(posedge clock);
            #1;
            sif.cmd_valid = 1'b0;
            if (!sif.res_valid || sif.res_data != held || sif.cmd_ready) ok = 1'b0;
         end
         chk("hold_stable", 32'(ok), 32'd1);
         sif.res_ready = 1'b1;
      end
      @(posedge clock);
      #1;
      sif.res_ready = 1'b0;
      chk("after_hs_valid", 32'(sif.res_valid), 32'd0);
      chk("after_hs_idle", {28'd0, sif.cmd_ready, alu_op}, {28'd0, 1'b1, 3'd0});

      if (op != 2'd2 && !s0) begin sh[0] = a; sh_v[0] = 1'b1; end
      if (!s1) begin sh[1] = b; sh_v[1] = 1'b1; end
   endtask

   initial begin
      int lat, acc1, acc2;
      n_reset       = 1'b0;
      sif.cmd_valid = 1'b0;
      sif.cmd_op    = 2'd0;
      sif.cmd_a     = '0;
      sif.cmd_b     = '0;
      sif.res_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_cmd_ready", 32'(sif.cmd_ready), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_res_valid", 32'(sif.res_valid), 32'd0);
      chk("rst_res", {23'd0, sif.res_zero, sif.res_data}, {23'd0, 1'b1, 8'h00});
      @(negedge clock);
      n_reset = 1'b1;
      @(posedge clock);
      #1;
      chk("post_rst_ready", 32'(sif.cmd_ready), 32'd1);

      run_cmd(2'd0, 8'h12, 8'h34, 0, lat, acc1);
      chk("add_lat_5", 32'(lat), 32'd5);
      chk("add_0x46", 32'(sif.res_data), 32'h46);
      run_cmd(2'd1, 8'h00, 8'h01, 0, lat, acc1);
      chk("sub_wrap_ff", 32'(sif.res_data), 32'hff);
      run_cmd(2'd2, 8'h77, 8'hff, 0, lat, acc1);
      chk("inc_lat_4", 32'(lat), 32'd4);
      chk("inc_wrap_zero", {23'd0, sif.res_zero, sif.res_data}, {23'd0, 1'b1, 8'h00});
      run_cmd(2'd0, 8'h21, 8'h43, 10, lat, acc1);

      run_cmd(2'd0, 8'h10, 8'h20, 0, lat, acc1);
      run_cmd(2'd0, 8'h30, 8'h40, 0, lat, acc2);
      chk("add_throughput_6", 32'(acc2 - acc1), 32'd6);

      run_cmd(2'd3, 8'h01, 8'h02, 0, lat, acc1);

      // Reset while in W1.
      sif.cmd_op    = 2'd0;
      sif.cmd_a     = 8'h55;
      sif.cmd_b     = 8'h66;
      sif.cmd_valid = 1'b1;
      @(posedge clock);
      #1;
      sif.cmd_valid = 1'b0;
      @(posedge clock);
      #1;
      chk("pre_rst_w1", 32'(alu_op), 32'd7);
      #2;
      n_reset = 1'b0;
      model_reset();
      #1;
      chk("midrst_alu_op", 32'(alu_op), 32'd0);
      chk("midrst_cmd_ready", 32'(sif.cmd_ready), 32'd0);
      @(negedge clock);
      #1;
      n_reset = 1'b1;
      #1;
      chk("midrst_release", {30'd0, sif.cmd_ready, sif.res_valid}, {30'd0, 1'b1, 1'b0});
      chk("midrst_res", {23'd0, sif.res_zero, sif.res_data}, {23'd0, 1'b1, 8'h00});
      @(posedge clock);
      #1;

`ifdef ALU_SEQ_SKIP_EN
      run_cmd(2'd0, 8'h05, 8'h03, 0, lat, acc1);
      chk("skip_add_8", 32'(sif.res_data), 32'h08);
      run_cmd(2'd1, 8'h05, 8'h03, 0, lat, acc1);
      chk("skip_sub_lat_3", 32'(lat), 32'd3);
      chk("skip_sub_2", 32'(sif.res_data), 32'h02);
      do_reset();
      run_cmd(2'd1, 8'h05, 8'h03, 0, lat, acc1);
      chk("noskip_after_rst_5", 32'(lat), 32'd5);
`endif

      for (int i = 0; i < 16; i++) begin
         logic [1:0] op;
         logic [7:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 1) == 1) ? sh[0] : 8'($urandom);
         b  = ($urandom_range(0, 1) == 1) ? sh[1] : 8'($urandom);
         run_cmd(op, a, b, int'($urandom_range(0, 3)), lat, acc1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
